// File: rtl/eth_rx_dispatcher.sv
// Ethernet II header parser that enables one protocol handler per frame, plus a two-slot TX request arbiter.
// Handler enable 1 cycle after header byte 13; tx_start 2 cycles after a send edge; RX has no backpressure, TX holds requests while tx_busy.
package Types;
    typedef enum logic [15:0] {
        IPV4 = 16'h0800,
        ARP  = 16'h0806
    } e_ethertype;

    typedef struct packed {
        logic [47:0] mac_destination;
        logic [47:0] mac_source;
        logic [15:0] ethertype;
    } st_eth_header;

    typedef struct packed {
        logic [47:0] mac_destination;
        logic [15:0] ethertype;
        logic [15:0] length;
        logic [31:0] handle;
    } st_eth_packet;
endpackage

module eth_rx_dispatcher #(
    parameter int MAX_HDR_BYTES = 14
) (
    input  logic                eth_clk,
    input  logic                rst_in,
    input  logic                frame_valid,
    input  logic [7:0]          data_rxd,
    input  logic                data_new,
    output Types::st_eth_header eth_header,
    output logic                arp_active,
    output logic                ipv4_active,
    input  logic                arp_finished,
    input  logic                ipv4_finished,
    input  logic                arp_send,
    input  Types::st_eth_packet arp_packet,
    input  logic                ipv4_send,
    input  Types::st_eth_packet ipv4_packet,
    input  logic                tx_busy,
    output logic                tx_start,
    output Types::st_eth_packet tx_packet,
    output logic [15:0]         rx_frames,
    output logic [15:0]         rx_dropped,
    output logic [15:0]         tx_dropped
);
    localparam int CW = $clog2(MAX_HDR_BYTES + 1);
    localparam logic [CW-1:0] LAST_BYTE = CW'(MAX_HDR_BYTES - 1);
    localparam int HW = $bits(Types::st_eth_header);

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DISPATCH, S_DRAIN} e_state;

    e_state              state;
    e_state              state_next;
    logic [CW-1:0]       byte_cnt;
    logic                armed;
    logic                sel_arp;
    logic                hdr_load;
    logic                hdr_last;
    logic                frame_inc;
    logic                drop_inc;
    logic [15:0]         rx_type;
    logic                type_arp;
    logic                type_ipv4;

    logic                arp_send_q;
    logic                ipv4_send_q;
    logic                arp_pend;
    logic                ipv4_pend;
    Types::st_eth_packet arp_slot;
    Types::st_eth_packet ipv4_slot;
    logic                arp_edge;
    logic                ipv4_edge;
    logic                issue;
    logic                issue_arp;
    logic                issue_ipv4;
    logic                arp_drop;
    logic                ipv4_drop;
    logic [16:0]         tx_drop_sum;
    logic                unused_finished;

    assign unused_finished = arp_finished ^ ipv4_finished;

    // The EtherType is judged from the stored high byte and the byte arriving now.
    assign rx_type   = {eth_header.ethertype[7:0], data_rxd};
    assign type_arp  = (rx_type == 16'(Types::ARP));
    assign type_ipv4 = (rx_type == 16'(Types::IPV4));
    assign hdr_last  = (state == S_HEADER) && frame_valid && data_new && (byte_cnt == LAST_BYTE);

    always_ff @(posedge eth_clk) begin
        if (rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A frame already in flight when reset lifts is drained rather than parsed mid-way.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (frame_valid && !armed) begin
                    state_next = S_DRAIN;
                end else if (frame_valid && data_new) begin
                    state_next = S_HEADER;
                end
            end
            S_HEADER: begin
                if (!frame_valid) begin
                    state_next = S_IDLE;
                end else if (hdr_last) begin
                    state_next = (type_arp || type_ipv4) ? S_DISPATCH : S_DRAIN;
                end
            end
            S_DISPATCH, S_DRAIN: begin
                if (!frame_valid) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        arp_active  = (state == S_DISPATCH) && sel_arp;
        ipv4_active = (state == S_DISPATCH) && !sel_arp;
        hdr_load    = frame_valid && data_new && (((state == S_IDLE) && armed) || (state == S_HEADER));
        frame_inc   = (state == S_DISPATCH) && !frame_valid;
        drop_inc    = (state == S_HEADER) && (!frame_valid || (hdr_last && !(type_arp || type_ipv4)));
    end

    always_ff @(posedge eth_clk) begin
        if (rst_in) begin
            byte_cnt   <= '0;
            armed      <= 1'b0;
            sel_arp    <= 1'b0;
            eth_header <= '0;
            rx_frames  <= '0;
            rx_dropped <= '0;
        end else begin
            if (!frame_valid) begin
                armed <= 1'b1;
            end
            if (state == S_IDLE) begin
                byte_cnt <= hdr_load ? CW'(1) : '0;
            end else if (hdr_load) begin
                byte_cnt <= byte_cnt + 1'b1;
            end
            if (hdr_load) begin
                eth_header <= Types::st_eth_header'({eth_header[HW-9:0], data_rxd});
            end
            if (hdr_last) begin
                sel_arp <= type_arp;
            end
            if (frame_inc && (rx_frames != 16'hFFFF)) begin
                rx_frames <= rx_frames + 16'd1;
            end
            if (drop_inc && (rx_dropped != 16'hFFFF)) begin
                rx_dropped <= rx_dropped + 16'd1;
            end
        end
    end

    assign arp_edge    = arp_send && !arp_send_q;
    assign ipv4_edge   = ipv4_send && !ipv4_send_q;
    assign issue       = !tx_busy && !tx_start && (arp_pend || ipv4_pend);
    assign issue_arp   = issue && arp_pend;
    assign issue_ipv4  = issue && !arp_pend;
    // A slot being issued this cycle is free to take the new request.
    assign arp_drop    = arp_edge && arp_pend && !issue_arp;
    assign ipv4_drop   = ipv4_edge && ipv4_pend && !issue_ipv4;
    assign tx_drop_sum = {1'b0, tx_dropped} + {16'd0, arp_drop} + {16'd0, ipv4_drop};

    always_ff @(posedge eth_clk) begin
        if (rst_in) begin
            arp_send_q  <= 1'b0;
            ipv4_send_q <= 1'b0;
            arp_pend    <= 1'b0;
            ipv4_pend   <= 1'b0;
            arp_slot    <= '0;
            ipv4_slot   <= '0;
            tx_start    <= 1'b0;
            tx_packet   <= '0;
            tx_dropped  <= '0;
        end else begin
            arp_send_q  <= arp_send;
            ipv4_send_q <= ipv4_send;
            if (arp_edge && (!arp_pend || issue_arp)) begin
                arp_slot <= arp_packet;
                arp_pend <= 1'b1;
            end else if (issue_arp) begin
                arp_pend <= 1'b0;
            end
            if (ipv4_edge && (!ipv4_pend || issue_ipv4)) begin
                ipv4_slot <= ipv4_packet;
                ipv4_pend <= 1'b1;
            end else if (issue_ipv4) begin
                ipv4_pend <= 1'b0;
            end
            tx_start <= issue;
            if (issue) begin
                tx_packet <= issue_arp ? arp_slot : ipv4_slot;
            end
            tx_dropped <= tx_drop_sum[16] ? 16'hFFFF : tx_drop_sum[15:0];
        end
    end
endmodule

// File: tb/tb_eth_rx_dispatcher.sv
// Randomised self-checking bench for eth_rx_dispatcher against a frame-level reference model.
module tb_eth_rx_dispatcher;
    import Types::*;

    typedef logic [7:0] byte_q_t[$];

    logic         eth_clk = 1'b0;
    logic         rst_in;
    logic         frame_valid;
    logic [7:0]   data_rxd;
    logic         data_new;
    st_eth_header eth_header;
    logic         arp_active;
    logic         ipv4_active;
    logic         arp_finished;
    logic         ipv4_finished;
    logic         arp_send;
    st_eth_packet arp_packet;
    logic         ipv4_send;
    st_eth_packet ipv4_packet;
    logic         tx_busy;
    logic         tx_start;
    st_eth_packet tx_packet;
    logic [15:0]  rx_frames;
    logic [15:0]  rx_dropped;
    logic [15:0]  tx_dropped;

    int checks = 0;
    int failures = 0;
    int exp_rx_frames = 0;
    int exp_rx_dropped = 0;
    int exp_tx_dropped = 0;

    // Observations recorded by send_frame for the scenario tasks to judge.
    logic         seen_early;
    logic         act_unstable;
    logic [1:0]   act13;
    logic [1:0]   act_before_end;
    logic [1:0]   act_end;
    st_eth_header hdr_seen;
    st_eth_header hdr_end;

    eth_rx_dispatcher #(.MAX_HDR_BYTES(14)) dut (
        .eth_clk(eth_clk), .rst_in(rst_in), .frame_valid(frame_valid), .data_rxd(data_rxd),
        .data_new(data_new), .eth_header(eth_header), .arp_active(arp_active),
        .ipv4_active(ipv4_active), .arp_finished(arp_finished), .ipv4_finished(ipv4_finished),
        .arp_send(arp_send), .arp_packet(arp_packet), .ipv4_send(ipv4_send),
        .ipv4_packet(ipv4_packet), .tx_busy(tx_busy), .tx_start(tx_start), .tx_packet(tx_packet),
        .rx_frames(rx_frames), .rx_dropped(rx_dropped), .tx_dropped(tx_dropped)
    );

    always #10 eth_clk = ~eth_clk;

    always @(negedge eth_clk) begin
        checks++;
        if (arp_active && ipv4_active) begin
            failures++;
            $display("FAIL both_active: arp=%0b ipv4=%0b required not both 1", arp_active, ipv4_active);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge eth_clk);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1; frame_valid = 1'b0; data_new = 1'b0;
        arp_send = 1'b0; ipv4_send = 1'b0; tx_busy = 1'b0;
        repeat (2) tick();
        rst_in = 1'b0;
        exp_rx_frames = 0; exp_rx_dropped = 0; exp_tx_dropped = 0;
        repeat (2) tick();
    endtask

    function automatic st_eth_packet rand_pkt();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return st_eth_packet'(r[111:0]);
    endfunction

    function automatic byte_q_t build_frame(input logic [47:0] d, input logic [47:0] s,
                                            input logic [15:0] t, input int npay);
        byte_q_t q;
        logic [111:0] h;
        h = {d, s, t};
        for (int i = 0; i < 14; i++) q.push_back(h[111 - 8*i -: 8]);
        for (int i = 0; i < npay; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic send_frame(input byte_q_t fr, input int gap);
        int n;
        n = fr.size();
        seen_early = 1'b0; act_unstable = 1'b0; act13 = 2'b00; hdr_seen = '0;
        for (int i = 0; i < n; i++) begin
            frame_valid = 1'b1; data_new = 1'b1; data_rxd = fr[i];
            tick();
            data_new = 1'b0; data_rxd = 8'($urandom);
            if (i < 13) begin
                if (arp_active || ipv4_active) seen_early = 1'b1;
            end else if (i == 13) begin
                act13 = {arp_active, ipv4_active};
                hdr_seen = eth_header;
            end else if ({arp_active, ipv4_active} != act13 || eth_header != hdr_seen) begin
                act_unstable = 1'b1;
            end
            for (int g = 1; g < gap; g++) begin
                tick();
                if (i < 13 && (arp_active || ipv4_active)) seen_early = 1'b1;
                if (i >= 13 && ({arp_active, ipv4_active} != act13 || eth_header != hdr_seen))
                    act_unstable = 1'b1;
            end
        end
        act_before_end = {arp_active, ipv4_active};
        frame_valid = 1'b0;
        tick();
        act_end = {arp_active, ipv4_active};
        hdr_end = eth_header;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (2) tick();
        checks++;
        if ({arp_active, ipv4_active, tx_start} !== 3'b000) begin
            failures++; $display("FAIL reset_flags: got %b required 000", {arp_active, ipv4_active, tx_start});
        end
        checks++;
        if ({rx_frames, rx_dropped, tx_dropped} !== 48'd0) begin
            failures++; $display("FAIL reset_counters: got %h required 0", {rx_frames, rx_dropped, tx_dropped});
        end
        checks++;
        if (eth_header !== '0 || tx_packet !== '0) begin
            failures++; $display("FAIL reset_buses: hdr=%h pkt=%h required 0", eth_header, tx_packet);
        end
        do_reset();
    endtask

    task automatic test_arp_frame();
        st_eth_header exp_h;
        exp_h = '{mac_destination: 48'hFFFF_FFFF_FFFF, mac_source: 48'h0200_0000_0001, ethertype: 16'h0806};
        send_frame(build_frame(exp_h.mac_destination, exp_h.mac_source, exp_h.ethertype, 28), 4);
        exp_rx_frames++;
        checks++;
        if (act13 !== 2'b10 || seen_early) begin
            failures++; $display("FAIL arp_rise: act=%b early=%0b required 10/0", act13, seen_early);
        end
        checks++;
        if (act_unstable || act_before_end !== 2'b10) begin
            failures++; $display("FAIL arp_hold: unstable=%0b last=%b required 0/10", act_unstable, act_before_end);
        end
        checks++;
        if (hdr_seen !== exp_h) begin
            failures++; $display("FAIL arp_header: got %h required %h", hdr_seen, exp_h);
        end
        checks++;
        if (act_end !== 2'b00 || hdr_end !== exp_h) begin
            failures++; $display("FAIL arp_end: act=%b hdr=%h required 00/%h", act_end, hdr_end, exp_h);
        end
        checks++;
        if (rx_frames !== 16'(exp_rx_frames)) begin
            failures++; $display("FAIL arp_rx_frames: got %0d required %0d", rx_frames, exp_rx_frames);
        end
    endtask

    task automatic test_unknown_type();
        send_frame(build_frame(48'h3333_0000_0001, 48'h0200_0000_0002, 16'h86DD, 12), 2);
        exp_rx_dropped++;
        checks++;
        if (act13 !== 2'b00 || act_unstable || act_end !== 2'b00) begin
            failures++; $display("FAIL unk_active: act=%b unstable=%0b end=%b required 00/0/00", act13, act_unstable, act_end);
        end
        checks++;
        if (rx_dropped !== 16'(exp_rx_dropped) || rx_frames !== 16'(exp_rx_frames)) begin
            failures++; $display("FAIL unk_counters: drop=%0d frames=%0d required %0d/%0d",
                                 rx_dropped, rx_frames, exp_rx_dropped, exp_rx_frames);
        end
        send_frame(build_frame(48'h0000_5E00_0001, 48'h0200_0000_0003, 16'h0806, 6), 3);
        exp_rx_frames++;
        checks++;
        if (act13 !== 2'b10 || rx_frames !== 16'(exp_rx_frames)) begin
            failures++; $display("FAIL unk_next_arp: act=%b frames=%0d required 10/%0d", act13, rx_frames, exp_rx_frames);
        end
    endtask

    task automatic test_runt();
        byte_q_t fr;
        st_eth_header exp_h;
        do_reset();
        fr = build_frame(48'h0102_0304_0506, 48'h0708_090A_0B0C, 16'h0806, 0);
        fr = fr[0:9];
        send_frame(fr, 2);
        exp_rx_dropped++;
        checks++;
        if (seen_early || act_end !== 2'b00 || rx_dropped !== 16'(exp_rx_dropped)) begin
            failures++; $display("FAIL runt: early=%0b end=%b drop=%0d required 0/00/%0d",
                                 seen_early, act_end, rx_dropped, exp_rx_dropped);
        end
        exp_h = '{mac_destination: 48'hA1A2_A3A4_A5A6, mac_source: 48'hB1B2_B3B4_B5B6, ethertype: 16'h0806};
        send_frame(build_frame(exp_h.mac_destination, exp_h.mac_source, exp_h.ethertype, 4), 2);
        exp_rx_frames++;
        checks++;
        if (act13 !== 2'b10 || hdr_seen !== exp_h) begin
            failures++; $display("FAIL runt_next: act=%b hdr=%h required 10/%h", act13, hdr_seen, exp_h);
        end
        checks++;
        if (rx_frames !== 16'(exp_rx_frames)) begin
            failures++; $display("FAIL runt_next_frames: got %0d required %0d", rx_frames, exp_rx_frames);
        end
    endtask

    task automatic test_random_frames();
        for (int k = 0; k < 14; k++) begin
            int kind;
            int gap;
            logic [47:0] d;
            logic [47:0] s;
            logic [15:0] t;
            logic [1:0] exp_act;
            byte_q_t fr;
            kind = $urandom_range(0, 3);
            gap = $urandom_range(2, 4);
            d = {16'($urandom), $urandom};
            s = {16'($urandom), $urandom};
            t = (kind == 0 || kind == 3) ? 16'h0806 : (kind == 1) ? 16'h0800 : 16'($urandom);
            if (kind == 2 && (t == 16'h0800 || t == 16'h0806)) t = 16'h88CC;
            fr = build_frame(d, s, t, $urandom_range(0, 10));
            if (kind == 3) fr = fr[0:$urandom_range(0, 12)];
            send_frame(fr, gap);
            exp_act = (fr.size() < 14) ? 2'b00 : (t == 16'h0806) ? 2'b10 : (t == 16'h0800) ? 2'b01 : 2'b00;
            if (exp_act == 2'b00) exp_rx_dropped++;
            else exp_rx_frames++;
            checks++;
            if (act13 !== exp_act || seen_early || act_unstable || act_end !== 2'b00) begin
                failures++; $display("FAIL rand_active[%0d]: act=%b early=%0b unstable=%0b end=%b required %b/0/0/00",
                                     k, act13, seen_early, act_unstable, act_end, exp_act);
            end
            if (exp_act != 2'b00) begin
                checks++;
                if (hdr_seen !== {d, s, t}) begin
                    failures++; $display("FAIL rand_header[%0d]: got %h required %h", k, hdr_seen, {d, s, t});
                end
            end
            checks++;
            if (rx_frames !== 16'(exp_rx_frames) || rx_dropped !== 16'(exp_rx_dropped)) begin
                failures++; $display("FAIL rand_counters[%0d]: frames=%0d drop=%0d required %0d/%0d",
                                     k, rx_frames, rx_dropped, exp_rx_frames, exp_rx_dropped);
            end
        end
    endtask

    task automatic test_send_latency();
        for (int k = 0; k < 8; k++) begin
            st_eth_packet p;
            logic use_arp;
            logic [1:0] seen;
            p = rand_pkt();
            use_arp = 1'($urandom);
            if (use_arp) begin arp_packet = p; arp_send = 1'b1; end
            else begin ipv4_packet = p; ipv4_send = 1'b1; end
            tick();
            seen[0] = tx_start;
            tick();
            seen[1] = tx_start;
            checks++;
            if (seen !== 2'b10 || tx_packet !== p) begin
                failures++; $display("FAIL latency[%0d]: start(c1,c2)=%b pkt=%h required 01 order/%h", k, seen, tx_packet, p);
            end
            arp_send = 1'b0; ipv4_send = 1'b0;
            tick();
            checks++;
            if (tx_start !== 1'b0) begin
                failures++; $display("FAIL latency_single[%0d]: tx_start=%0b required 0", k, tx_start);
            end
            tick();
        end
    endtask

    task automatic test_simultaneous_sends();
        st_eth_packet pa;
        st_eth_packet pi;
        logic bad;
        pa = rand_pkt(); pi = rand_pkt();
        arp_packet = pa; ipv4_packet = pi; arp_send = 1'b1; ipv4_send = 1'b1;
        tick();
        checks++;
        if (tx_start !== 1'b0) begin
            failures++; $display("FAIL sim_early: tx_start=%0b required 0", tx_start);
        end
        tick();
        checks++;
        if (tx_start !== 1'b1 || tx_packet !== pa) begin
            failures++; $display("FAIL sim_first: start=%0b pkt=%h required 1/%h", tx_start, tx_packet, pa);
        end
        tx_busy = 1'b1; arp_send = 1'b0; ipv4_send = 1'b0;
        arp_packet = rand_pkt(); ipv4_packet = rand_pkt();
        bad = 1'b0;
        repeat (10) begin
            tick();
            if (tx_start) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++; $display("FAIL sim_busy: tx_start seen=%0b required 0", bad);
        end
        tx_busy = 1'b0;
        tick();
        checks++;
        if (tx_start !== 1'b1 || tx_packet !== pi) begin
            failures++; $display("FAIL sim_second: start=%0b pkt=%h required 1/%h", tx_start, tx_packet, pi);
        end
        tick();
        checks++;
        if (tx_start !== 1'b0) begin
            failures++; $display("FAIL sim_spacing: tx_start=%0b required 0", tx_start);
        end
        repeat (2) tick();
    endtask

    task automatic test_overflow();
        st_eth_packet p[3];
        logic bad;
        tx_busy = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            p[k] = rand_pkt();
            arp_packet = p[k]; arp_send = 1'b1;
            tick();
            arp_send = 1'b0;
            tick();
        end
        exp_tx_dropped += 2;
        checks++;
        if (tx_dropped !== 16'(exp_tx_dropped)) begin
            failures++; $display("FAIL ovf_dropped: got %0d required %0d", tx_dropped, exp_tx_dropped);
        end
        tx_busy = 1'b0;
        tick();
        checks++;
        if (tx_start !== 1'b1 || tx_packet !== p[0]) begin
            failures++; $display("FAIL ovf_issue: start=%0b pkt=%h required 1/%h", tx_start, tx_packet, p[0]);
        end
        bad = 1'b0;
        repeat (4) begin
            tick();
            if (tx_start) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++; $display("FAIL ovf_extra: extra tx_start=%0b required 0", bad);
        end
    endtask

    task automatic test_same_cycle_issue();
        st_eth_packet p0;
        st_eth_packet p1;
        p0 = rand_pkt(); p1 = rand_pkt();
        tx_busy = 1'b1;
        arp_packet = p0; arp_send = 1'b1;
        tick();
        arp_send = 1'b0;
        tick();
        tx_busy = 1'b0; arp_packet = p1; arp_send = 1'b1;
        tick();
        checks++;
        if (tx_start !== 1'b1 || tx_packet !== p0) begin
            failures++; $display("FAIL same_old: start=%0b pkt=%h required 1/%h", tx_start, tx_packet, p0);
        end
        arp_send = 1'b0;
        tick();
        tick();
        checks++;
        if (tx_start !== 1'b1 || tx_packet !== p1) begin
            failures++; $display("FAIL same_new: start=%0b pkt=%h required 1/%h", tx_start, tx_packet, p1);
        end
        checks++;
        if (tx_dropped !== 16'(exp_tx_dropped)) begin
            failures++; $display("FAIL same_nodrop: got %0d required %0d", tx_dropped, exp_tx_dropped);
        end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_dispatch();
        byte_q_t fr;
        logic bad;
        fr = build_frame(48'h0A0B_0C0D_0E0F, 48'h0200_0000_0099, 16'h0800, 20);
        for (int i = 0; i < 18; i++) begin
            frame_valid = 1'b1; data_new = 1'b1; data_rxd = fr[i];
            tick();
            data_new = 1'b0;
            tick();
        end
        checks++;
        if (ipv4_active !== 1'b1) begin
            failures++; $display("FAIL rmd_before: ipv4_active=%0b required 1", ipv4_active);
        end
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        exp_rx_frames = 0; exp_rx_dropped = 0; exp_tx_dropped = 0;
        checks++;
        if ({arp_active, ipv4_active} !== 2'b00) begin
            failures++; $display("FAIL rmd_active: got %b required 00", {arp_active, ipv4_active});
        end
        checks++;
        if ({rx_frames, rx_dropped, tx_dropped} !== 48'd0) begin
            failures++; $display("FAIL rmd_counters: got %h required 0", {rx_frames, rx_dropped, tx_dropped});
        end
        bad = 1'b0;
        for (int i = 18; i < fr.size(); i++) begin
            data_new = 1'b1; data_rxd = fr[i];
            tick();
            data_new = 1'b0;
            if (arp_active || ipv4_active) bad = 1'b1;
            tick();
            if (arp_active || ipv4_active) bad = 1'b1;
        end
        frame_valid = 1'b0;
        tick();
        checks++;
        if (bad || rx_frames !== 16'd0 || rx_dropped !== 16'd0) begin
            failures++; $display("FAIL rmd_tail: active_seen=%0b frames=%0d drop=%0d required 0/0/0", bad, rx_frames, rx_dropped);
        end
        tick();
        send_frame(build_frame(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0806, 3), 3);
        exp_rx_frames++;
        checks++;
        if (act13 !== 2'b10 || rx_frames !== 16'(exp_rx_frames)) begin
            failures++; $display("FAIL rmd_resync: act=%b frames=%0d required 10/%0d", act13, rx_frames, exp_rx_frames);
        end
    endtask

    initial begin
        rst_in = 1'b1; frame_valid = 1'b0; data_rxd = 8'd0; data_new = 1'b0;
        arp_finished = 1'b0; ipv4_finished = 1'b0;
        arp_send = 1'b0; ipv4_send = 1'b0; arp_packet = '0; ipv4_packet = '0; tx_busy = 1'b0;
        test_reset();
        test_arp_frame();
        test_unknown_type();
        test_runt();
        test_random_frames();
        test_send_latency();
        test_simultaneous_sends();
        test_overflow();
        test_same_cycle_issue();
        test_reset_mid_dispatch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
